multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Purpose: bundles the multicycle controller's opcode/handshake inputs and datapath control outputs.
// Latency: none. This file only carries wires.
// Backpressure: mem_ready stalls the controller in FETCH, MEMRD and MEMWR.
// Ports: OP, mem_ready (to controller); strobes, selects, ALUOp, instr_done, illegal_op, state (from controller).
interface multicycle_control_if;
    logic [5:0] OP;
    logic       mem_ready;

    logic       PCWrite;
    logic       BranchEQ;
    logic       BranchNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    // Controller side: consumes opcode and memory handshake, drives the datapath.
    modport slave (
        input  OP, mem_ready,
        output PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               instr_done, illegal_op, state
    );

    // Datapath/bench side: supplies opcode and handshake, observes the controls.
    modport master (
        output OP, mem_ready,
        input  PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               instr_done, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Purpose: multicycle MIPS-style control FSM (FETCH/DECODE/execute/writeback) driving datapath strobes.
// Latency: LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ/BNE 3, J 3 cycles with mem_ready held high.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR; each low cycle adds one cycle.
// Ports: clk, reset (async active-low); bus (slave modport) carries OP, mem_ready and all control outputs.
module multicycle_control (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.slave    bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_FN  = 3'b111;
    localparam logic [2:0] ALU_SUB = 3'b001;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // Raw (ungated) control values from the output decoder.
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;

    // State register and opcode latch. The opcode is captured only in DECODE
    // so later states are immune to the instruction register changing under us.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= bus.OP;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        memto_reg  = 1'b0;
        alu_src_a  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        pc_source  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                // PC+4 is computed every cycle; IR and PC only commit when the read lands.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
                case (bus.OP)
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_RTYPE:        state_d = EXEC;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_ADDI, OP_ORI: state_d = IEXEC;
                    OP_J:            state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
                state_d   = (op_q == OP_SW) ? MEMWR : MEMRD;
            end

            MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                reg_write  = 1'b1;
                memto_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            MEMWR: begin
                // The store retires in the cycle the memory accepts it.
                mem_write  = 1'b1;
                ior_d      = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end

            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FN;
                state_d   = ALUWB;
            end

            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'b01;
                branch_eq  = (op_q == OP_BEQ);
                branch_ne  = (op_q == OP_BNE);
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
                state_d   = IWB;
            end

            IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs are gated by reset so that asserting it silences every strobe
    // immediately, without waiting for a clock edge.
    assign bus.PCWrite    = reset & pc_write;
    assign bus.BranchEQ   = reset & branch_eq;
    assign bus.BranchNE   = reset & branch_ne;
    assign bus.IorD       = reset & ior_d;
    assign bus.MemRead    = reset & mem_read;
    assign bus.MemWrite   = reset & mem_write;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.MemtoReg   = reset & memto_reg;
    assign bus.ALUSrcA    = reset & alu_src_a;
    assign bus.RegWrite   = reset & reg_write;
    assign bus.RegDst     = reset & reg_dst;
    assign bus.PCSource   = {2{reset}} & pc_source;
    assign bus.ALUSrcB    = {2{reset}} & alu_src_b;
    assign bus.ALUOp      = {3{reset}} & alu_op;
    assign bus.instr_done = reset & instr_done;
    assign bus.illegal_op = reset & illegal_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control against an instruction-path reference model.
// Latency: model follows per-opcode state paths; one compare per cycle on the falling edge.
// Backpressure: mem_ready randomized; FETCH/MEMRD/MEMWR hold while it is low.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } out_t;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of states still to visit in the current instruction,
    // plus the opcode captured when DECODE was passed.
    int         mq[$];
    logic [5:0] m_lat;

    logic [3:0] tr_s[$];
    out_t       tr_o[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.pc_write   = bus.PCWrite;
        o.branch_eq  = bus.BranchEQ;
        o.branch_ne  = bus.BranchNE;
        o.ior_d      = bus.IorD;
        o.mem_read   = bus.MemRead;
        o.mem_write  = bus.MemWrite;
        o.ir_write   = bus.IRWrite;
        o.memto_reg  = bus.MemtoReg;
        o.alu_src_a  = bus.ALUSrcA;
        o.reg_write  = bus.RegWrite;
        o.reg_dst    = bus.RegDst;
        o.pc_source  = bus.PCSource;
        o.alu_src_b  = bus.ALUSrcB;
        o.alu_op     = bus.ALUOp;
        o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    function automatic logic supported(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h05 ||
               op == 6'h08 || op == 6'h0D || op == 6'h23 || op == 6'h2B;
    endfunction

    // Expected controls for a state, given the latched opcode and live inputs.
    function automatic out_t exp_out(input int st, input logic [5:0] lat,
                                     input logic [5:0] live, input logic mr);
        out_t o = '0;
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b100;
                      o.ir_write = mr; o.pc_write = mr; end
            1:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.illegal_op = !supported(live); end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
            3:  begin o.mem_read = 1; o.ior_d = 1; end
            4:  begin o.reg_write = 1; o.memto_reg = 1; o.instr_done = 1; end
            5:  begin o.mem_write = 1; o.ior_d = 1; o.instr_done = mr; end
            6:  begin o.alu_src_a = 1; o.alu_op = 3'b111; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_source = 2'b01;
                      o.branch_eq = (lat == 6'h04); o.branch_ne = (lat == 6'h05);
                      o.instr_done = 1; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10;
                      o.alu_op = (lat == 6'h0D) ? 3'b101 : 3'b100; end
            10: begin o.reg_write = 1; o.instr_done = 1; end
            11: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // States an opcode visits after DECODE.
    function automatic void push_path(input logic [5:0] op);
        case (op)
            6'h23:        begin mq.push_back(2); mq.push_back(3); mq.push_back(4); end
            6'h2B:        begin mq.push_back(2); mq.push_back(5); end
            6'h00:        begin mq.push_back(6); mq.push_back(7); end
            6'h04, 6'h05: mq.push_back(8);
            6'h08, 6'h0D: begin mq.push_back(9); mq.push_back(10); end
            6'h02:        mq.push_back(11);
            default:      ;
        endcase
    endfunction

    function automatic void model_reset();
        mq.delete();
        mq.push_back(0);
        mq.push_back(1);
        m_lat = 6'h00;
    endfunction

    function automatic void model_step(input logic [5:0] op, input logic mr);
        int cur = mq[0];
        if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
        void'(mq.pop_front());
        if (cur == 1) begin
            m_lat = op;
            push_path(op);
        end
        if (mq.size() == 0) begin
            mq.push_back(0);
            mq.push_back(1);
        end
    endfunction

    task automatic compare();
        logic [3:0] es = 4'(mq[0]);
        out_t e = exp_out(mq[0], m_lat, bus.OP, bus.mem_ready);
        check($sformatf("state exp=%0d", es), bus.state, es);
        check($sformatf("outputs in state %0d", es), dut_out(), e);
    endtask

    // Entered #1 after a rising edge; leaves #1 after the next rising edge.
    task automatic run_cycle(input logic [5:0] op, input logic mr);
        bus.OP = op;
        bus.mem_ready = mr;
        @(negedge clk);
        compare();
        tr_s.push_back(bus.state);
        tr_o.push_back(dut_out());
        @(posedge clk);
        model_step(op, mr);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("async reset state", bus.state, 4'd0);
        check("async reset outputs", dut_out(), 20'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [5:0] opl [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
        int e34[5] = '{0, 1, 6, 7, 0};
        int e35[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        int e36[4] = '{0, 1, 8, 0};
        int e38[3] = '{0, 1, 0};

        reset = 1'b0;
        bus.OP = 6'h00;
        bus.mem_ready = 1'b1;
        model_reset();
        #2;
        check("reset state", bus.state, 4'd0);
        check("reset outputs (mem_ready=1)", dut_out(), 20'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // R-type
        tr_s.delete(); tr_o.delete();
        for (int i = 0; i < 4; i++) run_cycle(6'h00, 1'b1);
        run_cycle(6'h00, 1'b0);
        for (int i = 0; i < 5; i++) check($sformatf("rtype seq[%0d]", i), tr_s[i], e34[i]);
        check("rtype ALUOp in EXEC", tr_o[2].alu_op, 3'b111);
        check("rtype RegWrite in EXEC", tr_o[2].reg_write, 1'b0);
        check("rtype RegWrite in ALUWB", tr_o[3].reg_write, 1'b1);
        check("rtype RegDst in ALUWB", tr_o[3].reg_dst, 1'b1);

        // LW with two wait cycles in MEMRD
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h23, 1'b1); run_cycle(6'h23, 1'b1); run_cycle(6'h23, 1'b1);
        run_cycle(6'h23, 1'b0); run_cycle(6'h23, 1'b0); run_cycle(6'h23, 1'b1);
        run_cycle(6'h23, 1'b1); run_cycle(6'h23, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("lw seq[%0d]", i), tr_s[i], e35[i]);
        check("lw MemRead/IorD in MEMRD", {tr_o[4].mem_read, tr_o[4].ior_d}, 2'b11);
        check("lw MemtoReg in MEMWB", tr_o[6].memto_reg, 1'b1);
        check("lw instr_done in MEMWB", tr_o[6].instr_done, 1'b1);

        // BNE
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h05, 1'b1); run_cycle(6'h05, 1'b1); run_cycle(6'h05, 1'b1);
        run_cycle(6'h05, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("bne seq[%0d]", i), tr_s[i], e36[i]);
        check("bne BranchNE/BranchEQ", {tr_o[2].branch_ne, tr_o[2].branch_eq}, 2'b10);
        check("bne ALUOp", tr_o[2].alu_op, 3'b001);
        check("bne PCSource", tr_o[2].pc_source, 2'b01);
        check("bne instr_done", tr_o[2].instr_done, 1'b1);

        // ORI with OP switched to ADDI once in IEXEC
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h0D, 1'b1); run_cycle(6'h0D, 1'b1);
        run_cycle(6'h08, 1'b1); run_cycle(6'h08, 1'b1); run_cycle(6'h08, 1'b0);
        check("ori state IEXEC", tr_s[2], 4'd9);
        check("ori ALUOp latched", tr_o[2].alu_op, 3'b101);
        check("ori ALUSrcB", tr_o[2].alu_src_b, 2'b10);
        check("ori IWB state", tr_s[3], 4'd10);

        // Illegal opcode
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h3F, 1'b1); run_cycle(6'h3F, 1'b1); run_cycle(6'h3F, 1'b0);
        for (int i = 0; i < 3; i++) check($sformatf("illegal seq[%0d]", i), tr_s[i], e38[i]);
        check("illegal_op in DECODE", tr_o[1].illegal_op, 1'b1);
        check("illegal_op after DECODE", tr_o[2].illegal_op, 1'b0);
        check("illegal no writes", {tr_o[1].reg_write, tr_o[1].mem_write,
                                    tr_o[2].reg_write, tr_o[2].mem_write}, 4'b0000);

        // Reset in the middle of a stalled store
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h2B, 1'b1); run_cycle(6'h2B, 1'b1); run_cycle(6'h2B, 1'b1);
        run_cycle(6'h2B, 1'b0);
        check("sw MEMWR state", tr_s[3], 4'd5);
        check("sw MemWrite before reset", tr_o[3].mem_write, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid-MEMWR reset MemWrite", bus.MemWrite, 1'b0);
        check("mid-MEMWR reset state", bus.state, 4'd0);
        model_reset();
        @(negedge clk);
        check("held reset outputs", dut_out(), 20'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tr_s.delete(); tr_o.delete();
        run_cycle(6'h00, 1'b1);
        check("post-reset IRWrite/PCWrite", {tr_o[0].ir_write, tr_o[0].pc_write}, 2'b11);

        // Randomized traffic with stalls, opcode churn and occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            logic       mr;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else                           op = opl[$urandom_range(0, 7)];
            mr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            run_cycle(op, mr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
